// File: rtl/sound_pkg.sv
// Shared definitions for the 68k-to-Z80 sound command mailbox.
package sound_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned STAT_W       = 16;
  localparam int unsigned STAT_PENDING = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVERRUN = 2;

  function automatic logic edge_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// Small synchronous FIFO with pop-before-push semantics so a full FIFO accepts
// a push that lands in the same clock as a pop.
module sync_fifo_small #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_c,
  output logic [CNT_W-1:0] count_o,
  output logic             full_c,
  output logic             empty_c,
  output logic             drop_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MEM_N = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [MEM_N];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_FULL);
  assign head_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap by explicit compare so any DEPTH works.
  always_comb begin
    pop_ok   = pop_i & ~empty_c;
    push_ok  = push_i & (~full_c | pop_ok);
    drop_c   = push_i & full_c & ~pop_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sound_latch_mailbox.sv
// 68k-to-Z80 sound command mailbox: edge-qualified bus cycles feed a small FIFO,
// with Z80 interrupt, read-back data and 68k handshake status.
module sound_latch_mailbox
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m68k_latch_cs,
  input  logic              m68k_sound_cs,
  input  logic [DATA_W-1:0] m68k_din,
  output logic [STAT_W-1:0] m68k_dout,
  input  logic              z80_latch_cs,
  input  logic              RD_n,
  input  logic              WR_n,
  output logic [DATA_W-1:0] z80_dout,
  output logic              z80_int_n,
  output logic              pending
);

  logic              prev_latch_q, prev_ack_q, prev_stat_q;
  logic [DATA_W-1:0] last_read_q, last_read_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] z80_dout_q, z80_dout_d;
  logic              int_n_q, int_n_d;
  logic              pending_q, pending_d;
  logic [STAT_W-1:0] m68k_dout_q, m68k_dout_d;

  logic              push_edge, ack_edge, stat_end;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_drop;
  logic              unused_rd_n;

  // Reads have no side effect on the mailbox.
  assign unused_rd_n = RD_n;

  sync_fifo_small #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_edge),
    .pop_i   (ack_edge),
    .din_i   (m68k_din),
    .head_c  (fifo_head),
    .count_o (fifo_count),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .drop_c  (fifo_drop)
  );

  always_comb begin
    push_edge   = edge_rise(m68k_latch_cs, prev_latch_q);
    ack_edge    = edge_rise(z80_latch_cs & ~WR_n, prev_ack_q);
    stat_end    = prev_stat_q & ~m68k_sound_cs;
    last_read_d = last_read_q;
    if (ack_edge && !fifo_empty) last_read_d = fifo_head;
    overrun_d = overrun_q;
    if (fifo_drop)     overrun_d = 1'b1;
    else if (stat_end) overrun_d = 1'b0;
    z80_dout_d  = fifo_empty ? last_read_q : fifo_head;
    int_n_d     = fifo_empty;
    pending_d   = ~fifo_empty;
    m68k_dout_d = '0;
    m68k_dout_d[STAT_PENDING] = ~fifo_empty;
    m68k_dout_d[STAT_FULL]    = fifo_full;
    m68k_dout_d[STAT_OVERRUN] = overrun_q;
    m68k_dout_d[15:8]         = 8'(fifo_count);
  end

  // During reset the strobe history tracks the live selects, so a select held
  // across the release is not seen as a new bus cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_latch_q <= m68k_latch_cs;
      prev_ack_q   <= z80_latch_cs & ~WR_n;
      prev_stat_q  <= m68k_sound_cs;
      last_read_q  <= '0;
      overrun_q    <= 1'b0;
      z80_dout_q   <= '0;
      int_n_q      <= 1'b1;
      pending_q    <= 1'b0;
      m68k_dout_q  <= '0;
    end else begin
      prev_latch_q <= m68k_latch_cs;
      prev_ack_q   <= z80_latch_cs & ~WR_n;
      prev_stat_q  <= m68k_sound_cs;
      last_read_q  <= last_read_d;
      overrun_q    <= overrun_d;
      z80_dout_q   <= z80_dout_d;
      int_n_q      <= int_n_d;
      pending_q    <= pending_d;
      m68k_dout_q  <= m68k_dout_d;
    end
  end

  assign m68k_dout = m68k_dout_q;
  assign z80_dout  = z80_dout_q;
  assign z80_int_n = int_n_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_sound_latch_mailbox.sv
// Directed bench: a DEPTH=1 and a DEPTH=4 mailbox share one stimulus stream.
module tb_sound_latch_mailbox;

  logic        clk;
  logic        reset;
  logic        lcs, scs, zcs, rd_n, wr_n;
  logic [7:0]  din;
  logic [15:0] mdo1, mdo4;
  logic [7:0]  zdo1, zdo4;
  logic        intn1, intn4, pend1, pend4;

  int n_tests = 0;
  int n_fail  = 0;

  sound_latch_mailbox #(.DEPTH(1), .CNT_W(4)) u_d1 (
    .clk(clk), .reset(reset), .m68k_latch_cs(lcs), .m68k_sound_cs(scs),
    .m68k_din(din), .m68k_dout(mdo1), .z80_latch_cs(zcs), .RD_n(rd_n),
    .WR_n(wr_n), .z80_dout(zdo1), .z80_int_n(intn1), .pending(pend1)
  );

  sound_latch_mailbox #(.DEPTH(4), .CNT_W(4)) u_d4 (
    .clk(clk), .reset(reset), .m68k_latch_cs(lcs), .m68k_sound_cs(scs),
    .m68k_din(din), .m68k_dout(mdo4), .z80_latch_cs(zcs), .RD_n(rd_n),
    .WR_n(wr_n), .z80_dout(zdo4), .z80_int_n(intn4), .pending(pend4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    din = b; lcs = 1'b1; cyc();
    lcs = 1'b0; cyc();
  endtask

  task automatic ack();
    zcs = 1'b1; wr_n = 1'b0; cyc();
    zcs = 1'b0; wr_n = 1'b1; cyc();
  endtask

  initial begin
    reset = 1'b1; lcs = 1'b1; scs = 1'b0; zcs = 1'b0;
    rd_n = 1'b1; wr_n = 1'b1; din = 8'hEE;

    // Reset with the 68k select held across the release
    cyc(2);
    reset = 1'b0;
    cyc(3);
    chk("rst_mdo1", mdo1, 16'h0000);
    chk("rst_int1", 16'(intn1), 16'h0001);
    chk("rst_zdo1", 16'(zdo1), 16'h0000);
    chk("rst_pend1", 16'(pend1), 16'h0000);
    chk("rst_mdo4", mdo4, 16'h0000);
    lcs = 1'b0;
    cyc();

    // Single push with long held select, then held ack
    din = 8'h5A; lcs = 1'b1;
    cyc();
    chk("push_int_lat", 16'(intn1), 16'h0001);
    cyc();
    chk("push_int1", 16'(intn1), 16'h0000);
    chk("push_zdo1", 16'(zdo1), 16'h005A);
    cyc(4);
    chk("held_mdo1", mdo1, 16'h0103);
    chk("held_mdo4", mdo4, 16'h0101);
    lcs = 1'b0; cyc();
    zcs = 1'b1; wr_n = 1'b0;
    cyc(3);
    zcs = 1'b0; wr_n = 1'b1;
    chk("ack_int1", 16'(intn1), 16'h0001);
    chk("ack_zdo1", 16'(zdo1), 16'h005A);
    chk("ack_mdo1", mdo1, 16'h0000);
    chk("ack_pend1", 16'(pend1), 16'h0000);
    cyc();

    // Overrun on DEPTH=1, then clear via a completed status read
    push(8'h11);
    push(8'h22);
    chk("ovr_mdo1", mdo1, 16'h0107);
    chk("ovr_zdo1", 16'(zdo1), 16'h0011);
    chk("ovr_mdo4", mdo4, 16'h0201);
    scs = 1'b1; cyc();
    scs = 1'b0; cyc(2);
    chk("clr_mdo1", mdo1, 16'h0103);
    ack();
    chk("ovr_ack_zdo1", 16'(zdo1), 16'h0011);
    chk("ovr_ack_mdo1", mdo1, 16'h0000);
    chk("ovr_ack_mdo4", mdo4, 16'h0101);
    chk("ovr_ack_zdo4", 16'(zdo4), 16'h0022);
    ack();
    chk("drain_mdo4", mdo4, 16'h0000);
    chk("drain_zdo4", 16'(zdo4), 16'h0022);

    // Wrap-around on DEPTH=4
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("full_mdo4", mdo4, 16'h0403);
    chk("full_zdo4", 16'(zdo4), 16'h0001);
    ack();
    chk("wrap_rd02", 16'(zdo4), 16'h0002);
    ack();
    chk("wrap_rd03", 16'(zdo4), 16'h0003);
    push(8'h05); push(8'h06);
    chk("wrap_full_mdo4", mdo4, 16'h0403);
    ack();
    chk("wrap_rd04", 16'(zdo4), 16'h0004);
    ack();
    chk("wrap_rd05", 16'(zdo4), 16'h0005);
    ack();
    chk("wrap_rd06", 16'(zdo4), 16'h0006);
    chk("wrap_int_held", 16'(intn4), 16'h0000);
    ack();
    chk("wrap_int_rel", 16'(intn4), 16'h0001);
    chk("wrap_last", 16'(zdo4), 16'h0006);

    // Same-clock push and ack on a full DEPTH=4 FIFO
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    din = 8'hB5; lcs = 1'b1; zcs = 1'b1; wr_n = 1'b0; cyc();
    lcs = 1'b0; zcs = 1'b0; wr_n = 1'b1; cyc();
    chk("sim_full_mdo4", mdo4, 16'h0403);
    chk("sim_full_head", 16'(zdo4), 16'h00A2);
    ack();
    chk("sim_rdA3", 16'(zdo4), 16'h00A3);
    ack();
    chk("sim_rdA4", 16'(zdo4), 16'h00A4);
    ack();
    chk("sim_tailB5", 16'(zdo4), 16'h00B5);
    ack();
    chk("sim_drain_mdo4", mdo4, 16'h0000);

    // Same-clock push and ack on an empty FIFO
    din = 8'hC6; lcs = 1'b1; zcs = 1'b1; wr_n = 1'b0; cyc();
    lcs = 1'b0; zcs = 1'b0; wr_n = 1'b1; cyc();
    chk("sim_empty_mdo4", mdo4, 16'h0101);
    chk("sim_empty_zdo4", 16'(zdo4), 16'h00C6);

    // Reset mid-operation with a push edge in the same clock
    push(8'hD7); push(8'hE8);
    chk("pre_rst_mdo4", mdo4, 16'h0301);
    reset = 1'b1; din = 8'hF9; lcs = 1'b1; cyc();
    reset = 1'b0; lcs = 1'b0; cyc(2);
    chk("mid_rst_mdo4", mdo4, 16'h0000);
    chk("mid_rst_int4", 16'(intn4), 16'h0001);
    chk("mid_rst_pend4", 16'(pend4), 16'h0000);
    chk("mid_rst_zdo4", 16'(zdo4), 16'h0000);
    chk("mid_rst_mdo1", mdo1, 16'h0000);
    push(8'h3C);
    chk("post_rst_mdo4", mdo4, 16'h0101);
    chk("post_rst_zdo4", 16'(zdo4), 16'h003C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_latch_mailbox.md
Name: sound_latch_mailbox

Overview:
- Implements the M68K→Z80 sound-command path that sits behind the decoded selects `m68k_latch_cs`, `m68k_sound_cs` and `z80_latch_cs`.
- 68k writes push a command byte into a small FIFO, and the Z80 interrupt is raised while data is pending.
- The Z80 reads the head byte and acknowledges it by writing to the latch address, which pops the FIFO.
- The 68k polls handshake status through the sound-status read port.

Parameters:
- DEPTH, 1, FIFO entries (1..8). DEPTH=1 is exactly a generic 8-bit latch.
- CNT_W, 4, occupancy counter width; must hold the value DEPTH.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- m68k_latch_cs  in  1  qualified 68k write select (level, held for the whole bus cycle)
- m68k_sound_cs  in  1  qualified 68k read select for status (level)
- m68k_din  in  8  68k data bus low byte
- m68k_dout  out  16  status word returned to the 68k
- z80_latch_cs  in  1  Z80 memory select of the latch address (level)
- RD_n  in  1  Z80 read strobe, active low
- WR_n  in  1  Z80 write strobe, active low
- z80_dout  out  8  latch read data to the Z80
- z80_int_n  out  1  Z80 maskable interrupt, active low
- pending  out  1  FIFO not empty (debug/OSD)

Behaviour:
- **Reset.** One clk with reset=1 clears everything. Outputs after reset: m68k_dout=16'h0000, z80_dout=8'h00, z80_int_n=1, pending=0. FIFO count, pointers and the overrun flag clear; the last-read register is set to 8'h00. Reset in the middle of a bus cycle discards that cycle. A select still held high when reset releases is not treated as a new edge.
- **Edge detection.** Each strobe is registered as prev_*:
  - push = m68k_latch_cs & !prev_latch
  - ack = (z80_latch_cs & !WR_n) & !prev_ack
  - status_rd_end = prev_stat & !m68k_sound_cs (falling edge)
  - Each bus cycle acts exactly once, however long the select is held.
- **Push.** On push, if count<DEPTH: mem[wr_ptr]<=m68k_din, wr_ptr increments mod DEPTH, count+1. If count==DEPTH the byte is dropped and overrun<=1 (sticky).
- **Pop.** On ack with count>0: last_read<=mem[rd_ptr], rd_ptr increments mod DEPTH, count-1. Ack on an empty FIFO is a no-op; no underflow flag.
- **Simultaneous push and ack in one clk.**
  - The pop is evaluated first, so a full FIFO accepts the push with no overrun. Count is unchanged.
  - On an empty FIFO, ack is a no-op and the push lands (count=1).
- **Z80 read data.** z80_dout is registered, updated every clk:
  - mem[rd_ptr] if count>0
  - otherwise last_read
  - Latency 1 clk from a change in the FIFO head.
- **Z80 interrupt.** z80_int_n = !(count>0), registered, 1 clk after the count change. It stays asserted until the FIFO drains; there is no Z80 IRQ-ack handling.
- **68k status.** m68k_dout, registered, updated every clk:
  - bit0 = pending
  - bit1 = full (count==DEPTH)
  - bit2 = overrun
  - bits7:3 = 0
  - bits15:8 = count zero-extended
  - m68k_dout is valid regardless of select; the bus mux gates it with m68k_sound_cs.
- **Overrun clear.** status_rd_end clears overrun. If an overrun occurs in the same clk as status_rd_end, set wins.
- **Pointer arithmetic.** Unsigned modulo DEPTH, with an explicit wrap compare (no power-of-two assumption). DEPTH=1 holds both pointers at 0.

Decomposition:
- Shared package (`sound_pkg`):
  - STAT_PENDING=0, STAT_FULL=1, STAT_OVERRUN=2 bit indices
  - function edge_rise(cur, prev)
- Natural sub-module: `sync_fifo_small`, parameterised DEPTH/width 8.
  - Inputs: push, pop.
  - Outputs: head, count, full, empty.
  - Implements the pop-before-push rule.
- The top level owns edge detection, last_read, overrun, interrupt and the status register.

Test Plan:
1. **Reset values.** Reset → m68k_dout=0000, z80_int_n=1, z80_dout=00. Hold m68k_latch_cs high across the reset release → no push.
2. **Single push, held select, then ack** (DEPTH=1). Push 8'h5A with m68k_latch_cs held 6 clks → count=1, z80_int_n=0 one clk after the edge, z80_dout=5A. Z80 ack write held 3 clks → count=0, z80_int_n=1, z80_dout stays 5A (last_read).
3. **Overrun, then clear.** DEPTH=1, push 11 then 22 → 22 dropped, m68k_dout=0x0107. End a status read → m68k_dout=0x0103. Ack → z80_dout=11, count 0.
4. **Wrap-around** (DEPTH=4). Push 01..04 (full, bit1=1). Ack twice, push 05, 06 → Z80 reads 03,04,05,06 in order across the wrap; int released after the final ack.
5. **Same-clk push and ack on a full FIFO** (DEPTH=4, full) → no overrun, count stays 4, head advances, new byte at the tail. Repeat on an empty FIFO → count=1.
6. **Reset mid-operation.** Reset asserted with count=3 and a push edge in the same clk → all state cleared, count=0, z80_int_n=1.
